// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: key edge detection, run/stop/lap/clear
// state machine, prescaler and mm:ss.hh counter chain with lap display.
module stopwatch_controller #(
   parameter int TICKS_PER_HUNDREDTH = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic [6:0] stopwatch_unit_mins,
   output logic [5:0] stopwatch_unit_secs,
   output logic [6:0] stopwatch_unit_decs,
   output logic       running,
   output logic       lap_active,
   output logic       rollover
);

   localparam int PW = $clog2(TICKS_PER_HUNDREDTH);
   localparam logic [PW-1:0] TERM = PW'(TICKS_PER_HUNDREDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOP,
      LAP
   } state_t;

   state_t state;
   state_t state_next;

   logic prev_ss;
   logic prev_lap;
   logic prev_clr;
   logic edge_ss;
   logic edge_lap;
   logic edge_clr;

   logic [PW-1:0] presc;
   logic          count_en;
   logic          tick;
   logic          capture;
   logic          zero_all;
   logic          at_max;
   logic          in_run;

   logic [6:0] live_mins;
   logic [5:0] live_secs;
   logic [6:0] live_decs;
   logic [6:0] lap_mins;
   logic [5:0] lap_secs;
   logic [6:0] lap_decs;

   assign edge_ss  = start_stop & ~prev_ss;
   assign edge_lap = lap & ~prev_lap;
   assign edge_clr = clear & ~prev_clr;

   assign in_run   = (state == RUN) || (state == LAP);
   // A start_stop edge that stops the watch also freezes this cycle's count.
   assign count_en = in_run && !edge_ss;
   assign tick     = count_en && (presc == TERM);
   assign at_max   = (live_mins == 7'd99) && (live_secs == 6'd59) &&
                     (live_decs == 7'd99);

   // Key history for rising-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_ss  <= 1'b0;
         prev_lap <= 1'b0;
         prev_clr <= 1'b0;
      end else begin
         prev_ss  <= start_stop;
         prev_lap <= lap;
         prev_clr <= clear;
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode with clear > start_stop > lap among legal edges
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      zero_all   = 1'b0;
      case (state)
         IDLE: begin
            if (edge_ss) state_next = RUN;
         end
         RUN: begin
            if (edge_ss) begin
               state_next = STOP;
            end else if (edge_lap) begin
               state_next = LAP;
               capture    = 1'b1;
            end
         end
         LAP: begin
            if (edge_ss)       state_next = STOP;
            else if (edge_lap) state_next = RUN;
         end
         STOP: begin
            if (edge_clr) begin
               state_next = IDLE;
               zero_all   = 1'b1;
            end else if (edge_ss) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Prescaler: counts while running, holds in STOP, zero in IDLE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else if (zero_all || state == IDLE) begin
         presc <= '0;
      end else if (count_en) begin
         if (tick) presc <= '0;
         else      presc <= presc + PW'(1);
      end
   end

   // Live counter chain advanced by the prescaler tick
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         live_mins <= '0;
         live_secs <= '0;
         live_decs <= '0;
      end else if (zero_all) begin
         live_mins <= '0;
         live_secs <= '0;
         live_decs <= '0;
      end else if (tick) begin
         if (live_decs == 7'd99) begin
            live_decs <= '0;
            if (live_secs == 6'd59) begin
               live_secs <= '0;
               if (live_mins == 7'd99) live_mins <= '0;
               else                    live_mins <= live_mins + 7'd1;
            end else begin
               live_secs <= live_secs + 6'd1;
            end
         end else begin
            live_decs <= live_decs + 7'd1;
         end
      end
   end

   // Lap registers take the pre-increment live value on capture
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lap_mins <= '0;
         lap_secs <= '0;
         lap_decs <= '0;
      end else if (zero_all) begin
         lap_mins <= '0;
         lap_secs <= '0;
         lap_decs <= '0;
      end else if (capture) begin
         lap_mins <= live_mins;
         lap_secs <= live_secs;
         lap_decs <= live_decs;
      end
   end

   // One-cycle pulse after the 99:59.99 wrap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rollover <= 1'b0;
      else       rollover <= tick && at_max;
   end

   // Display mux and status decode
   always_comb begin
      running             = in_run;
      lap_active          = (state == LAP);
      stopwatch_unit_mins = live_mins;
      stopwatch_unit_secs = live_secs;
      stopwatch_unit_decs = live_decs;
      if (state == LAP) begin
         stopwatch_unit_mins = lap_mins;
         stopwatch_unit_secs = lap_secs;
         stopwatch_unit_decs = lap_decs;
      end
   end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: a centisecond-count reference
// model feeds expected outputs to a monitor that checks every cycle.
module tb_stopwatch_controller;

   localparam int T     = 4;
   localparam int TOTAL = 100 * 60 * 100;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;
   localparam int M_LAP  = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_stop = 1'b0;
   logic       lap = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] mins;
   logic [5:0] secs;
   logic [6:0] decs;
   logic       running;
   logic       lap_active;
   logic       rollover;

   stopwatch_controller #(.TICKS_PER_HUNDREDTH(T)) dut (
      .clock               (clock),
      .reset               (reset),
      .start_stop          (start_stop),
      .lap                 (lap),
      .clear               (clear),
      .stopwatch_unit_mins (mins),
      .stopwatch_unit_secs (secs),
      .stopwatch_unit_decs (decs),
      .running             (running),
      .lap_active          (lap_active),
      .rollover            (rollover)
   );

   always #5 clock = ~clock;

   typedef struct {
      int    m;
      int    s;
      int    d;
      bit    run;
      bit    lapa;
      bit    roll;
      string tag;
   } exp_t;

   exp_t sb[$];
   event chk_ev;
   int   compared = 0;
   int   mismatched = 0;

   // reference model state
   int mode = M_IDLE;
   int live_cs = 0;
   int lap_cs = 0;
   int phase = 0;
   bit roll = 0;
   bit p_ss = 0;
   bit p_lp = 0;
   bit p_cl = 0;

   bit kss = 0;
   bit klp = 0;
   bit kcl = 0;

   function automatic void model_reset();
      mode = M_IDLE;
      live_cs = 0;
      lap_cs = 0;
      phase = 0;
      roll = 0;
      p_ss = 0;
      p_lp = 0;
      p_cl = 0;
   endfunction

   function automatic void model_step(bit ss, bit lp, bit cl);
      bit e_ss;
      bit e_lp;
      bit e_cl;
      bit active;
      e_ss = ss && !p_ss;
      e_lp = lp && !p_lp;
      e_cl = cl && !p_cl;
      p_ss = ss;
      p_lp = lp;
      p_cl = cl;
      roll = 0;
      active = (mode == M_RUN || mode == M_LAP) && !e_ss;
      if (mode == M_RUN && !e_ss && e_lp) lap_cs = live_cs;
      if (active) begin
         if (phase == T - 1) begin
            phase = 0;
            live_cs = live_cs + 1;
            if (live_cs == TOTAL) begin
               live_cs = 0;
               roll = 1;
            end
         end else begin
            phase = phase + 1;
         end
      end
      case (mode)
         M_IDLE: if (e_ss) mode = M_RUN;
         M_RUN: begin
            if (e_ss)      mode = M_STOP;
            else if (e_lp) mode = M_LAP;
         end
         M_LAP: begin
            if (e_ss)      mode = M_STOP;
            else if (e_lp) mode = M_RUN;
         end
         default: begin
            if (e_cl) begin
               mode = M_IDLE;
               live_cs = 0;
               lap_cs = 0;
               phase = 0;
            end else if (e_ss) begin
               mode = M_RUN;
            end
         end
      endcase
   endfunction

   function automatic exp_t model_out(string tag);
      exp_t e;
      int   cs;
      cs = (mode == M_LAP) ? lap_cs : live_cs;
      e.m = cs / 6000;
      e.s = (cs / 100) % 60;
      e.d = cs % 100;
      e.run = (mode == M_RUN || mode == M_LAP);
      e.lapa = (mode == M_LAP);
      e.roll = roll;
      e.tag = tag;
      return e;
   endfunction

   task automatic step(input string tag);
      @(negedge clock);
      start_stop = kss;
      lap = klp;
      clear = kcl;
      model_step(kss, klp, kcl);
      sb.push_back(model_out(tag));
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic press(input bit s, input bit l, input bit c,
                        input string tag);
      kss = s;
      klp = l;
      kcl = c;
      step(tag);
      kss = 0;
      klp = 0;
      kcl = 0;
      step(tag);
   endtask

   task automatic wait_phase_end();
      int guard;
      guard = 0;
      while (phase != T - 1 && guard < 16) begin
         step("align");
         guard++;
      end
   endtask

   task automatic run_to(input int cs, input string tag);
      int guard;
      guard = 0;
      while (live_cs != cs && guard < 40000) begin
         step(tag);
         guard++;
      end
   endtask

   // Monitor: compares every expected entry against the live outputs
   initial begin
      exp_t e;
      forever begin
         @(posedge clock or chk_ev);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            compared++;
            if (int'(mins) != e.m || int'(secs) != e.s ||
                int'(decs) != e.d || running != e.run ||
                lap_active != e.lapa || rollover != e.roll) begin
               mismatched++;
               $display("FAIL %s t=%0t got %0d:%0d.%0d r%0b l%0b o%0b want %0d:%0d.%0d r%0b l%0b o%0b",
                        e.tag, $time, mins, secs, decs, running,
                        lap_active, rollover, e.m, e.s, e.d, e.run,
                        e.lapa, e.roll);
            end
         end
      end
   end

   // Stimulus
   initial begin
      exp_t z;
      z.m = 0;
      z.s = 0;
      z.d = 0;
      z.run = 0;
      z.lapa = 0;
      z.roll = 0;

      #2;
      z.tag = "reset_state";
      sb.push_back(z);
      -> chk_ev;
      @(negedge clock);
      reset = 0;

      run(3, "idle_hold");
      press(0, 1, 1, "idle_ignores");
      press(1, 0, 0, "start");
      run(400, "run_one_sec");
      run_to(5999, "to_59_99");
      run(4, "secs_carry");

      press(0, 0, 1, "clear_in_run");
      wait_phase_end();
      press(1, 0, 0, "stop_on_tick");
      run(100, "stop_hold");
      press(0, 1, 0, "lap_in_stop");
      press(0, 0, 1, "clear_in_stop");
      run(10, "cleared_idle");
      press(1, 0, 0, "restart");
      run(8, "first_tick");

      run_to(50, "to_0_50");
      press(0, 1, 0, "lap_on");
      run(40, "lap_frozen");
      wait_phase_end();
      press(0, 1, 0, "lap_off_tick");
      wait_phase_end();
      press(0, 1, 0, "lap_on_tick");
      run(12, "lap_frozen2");
      press(1, 0, 0, "stop_from_lap");
      run(6, "stop_live");
      press(1, 0, 0, "resume");
      run(13, "resumed");

      press(1, 0, 0, "stop_preload");
      @(negedge clock);
      #1;
      force dut.live_mins = 7'd99;
      force dut.live_secs = 6'd59;
      force dut.live_decs = 7'd90;
      #1;
      release dut.live_mins;
      release dut.live_secs;
      release dut.live_decs;
      live_cs = TOTAL - 10;
      press(1, 0, 0, "resume_near_max");
      run(60, "rollover");

      press(1, 0, 0, "stop_again");
      press(1, 0, 1, "clear_and_ss");
      run(4, "after_both");
      press(1, 0, 0, "start_again");
      run(37, "pre_reset_run");

      @(negedge clock);
      #3;
      reset = 1;
      z.tag = "async_reset";
      sb.push_back(z);
      -> chk_ev;
      model_reset();
      @(negedge clock);
      reset = 0;
      run(10, "idle_after_reset");

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 23) == 0) kss = ~kss;
         if ($urandom_range(0, 17) == 0) klp = ~klp;
         if ($urandom_range(0, 59) == 0) kcl = ~kcl;
         step("random");
      end
      kss = 0;
      klp = 0;
      kcl = 0;
      run(5, "drain");

      @(posedge clock);
      #3;
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL sb_drain left=%0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
